// File: rtl/xover_coeff_scheduler.sv
// Shadow/active crossover coefficient banks; commits swap shadow->active just after a sample strobe.
// Optional macro XOVER_STABILITY_CHECK_EN adds a per-stage biquad stability check before the swap.
module xover_coeff_scheduler #(
  parameter int NUM_XOVER   = 3,
  parameter int COEFF_W     = 16,
  parameter int TIMEOUT_CYC = 4096,
  localparam int STAGE_W    = (NUM_XOVER > 1) ? $clog2(NUM_XOVER) : 1,
  localparam int TOTAL_W    = NUM_XOVER * 5 * COEFF_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [STAGE_W-1:0] wr_stage,
  input  logic [2:0]         wr_tap,
  input  logic [COEFF_W-1:0] wr_data,
  input  logic               commit_req,
  input  logic               sample_valid,
  output logic               busy,
  output logic               commit_ack,
  output logic               commit_err,
  output logic               err_addr,
  output logic               coeff_update,
  output logic [TOTAL_W-1:0] coeffs_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  function automatic logic [TOTAL_W-1:0] pass_set();
    logic [TOTAL_W-1:0] v;
    v = '0;
    for (int s = 0; s < NUM_XOVER; s++) begin
      v[(s*5)*COEFF_W +: COEFF_W] = COEFF_W'(16384);
    end
    return v;
  endfunction

  localparam logic [TOTAL_W-1:0] PASS = pass_set();

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    PEND  = 3'd3,
    SWAP  = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [TOTAL_W-1:0] shadow, active;
  logic               dirty;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               ack_nx, upd_nx, swap_en;
  logic               wr_acc, addr_ok, wr_hit, dirty_eff;

  assign wr_ready   = (state == IDLE) || (state == LOAD);
  assign busy       = (state == CHECK) || (state == PEND) || (state == SWAP);
  assign coeffs_out = active;

  assign wr_acc    = wr_valid && wr_ready;
  assign addr_ok   = ({1'b0, wr_stage} < (STAGE_W+1)'(NUM_XOVER)) && (wr_tap < 3'd5);
  assign wr_hit    = wr_acc && addr_ok;
  // A write landing in the same cycle as commit_req belongs to that commit.
  assign dirty_eff = dirty || wr_hit;

`ifdef XOVER_STABILITY_CHECK_EN
  logic [STAGE_W-1:0] chk_idx, chk_idx_nx;
  logic [COEFF_W-1:0] chk_a1, chk_a2;
  logic               stage_ok, err_nx;

  // Stable biquad: |a2| < 1.0 and |a1| < 1.0 + a2, evaluated with two guard bits.
  function automatic logic stable(input logic [COEFF_W-1:0] a1, input logic [COEFF_W-1:0] a2);
    logic signed [COEFF_W+1:0] e1, e2, m1, m2, one;
    one = (COEFF_W+2)'(16384);
    e1  = {{2{a1[COEFF_W-1]}}, a1};
    e2  = {{2{a2[COEFF_W-1]}}, a2};
    m1  = e1[COEFF_W+1] ? -e1 : e1;
    m2  = e2[COEFF_W+1] ? -e2 : e2;
    return (m2 < one) && (m1 < (one + e2));
  endfunction

  always_comb begin
    chk_a1 = '0;
    chk_a2 = '0;
    for (int s = 0; s < NUM_XOVER; s++) begin
      chk_a1 = (chk_idx == STAGE_W'(s)) ? shadow[(s*5+3)*COEFF_W +: COEFF_W] : chk_a1;
      chk_a2 = (chk_idx == STAGE_W'(s)) ? shadow[(s*5+4)*COEFF_W +: COEFF_W] : chk_a2;
    end
    stage_ok = stable(chk_a1, chk_a2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_idx    <= '0;
      commit_err <= 1'b0;
    end else begin
      chk_idx    <= chk_idx_nx;
      commit_err <= err_nx;
    end
  end
`else
  assign commit_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ack_nx   = 1'b0;
    upd_nx   = 1'b0;
    swap_en  = 1'b0;
`ifdef XOVER_STABILITY_CHECK_EN
    chk_idx_nx = '0;
    err_nx     = 1'b0;
`endif
    case (state)
      IDLE, LOAD: begin
        if (commit_req) begin
          if (dirty_eff) begin
            state_nx = CHECK;
          end else begin
            state_nx = IDLE;
            ack_nx   = 1'b1;
          end
        end else if (wr_acc) begin
          state_nx = LOAD;
        end else begin
          state_nx = state;
        end
      end
      CHECK: begin
`ifdef XOVER_STABILITY_CHECK_EN
        if (!stage_ok) begin
          state_nx = LOAD;
          err_nx   = 1'b1;
        end else if (chk_idx == STAGE_W'(NUM_XOVER-1)) begin
          state_nx = PEND;
        end else begin
          chk_idx_nx = chk_idx + 1'b1;
        end
`else
        state_nx = PEND;
`endif
      end
      PEND: begin
        cnt_nx = cnt + 1'b1;
        if (sample_valid || (cnt == CNT_W'(TIMEOUT_CYC-1))) begin
          state_nx = SWAP;
        end else begin
          state_nx = PEND;
        end
      end
      SWAP: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        ack_nx   = 1'b1;
        upd_nx   = 1'b1;
        swap_en  = 1'b1;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shadow       <= PASS;
      active       <= PASS;
      dirty        <= 1'b0;
      cnt          <= '0;
      commit_ack   <= 1'b0;
      coeff_update <= 1'b0;
      err_addr     <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      commit_ack   <= ack_nx;
      coeff_update <= upd_nx;
      if (swap_en) begin
        active <= shadow;
        dirty  <= 1'b0;
      end else if (wr_hit) begin
        dirty <= 1'b1;
      end
      if (wr_acc && !addr_ok) begin
        err_addr <= 1'b1;
      end
      // Shadow is never cleared by a swap, so later partial edits build on it.
      for (int s = 0; s < NUM_XOVER; s++) begin
        for (int t = 0; t < 5; t++) begin
          if (wr_hit && (wr_stage == STAGE_W'(s)) && (wr_tap == 3'(t))) begin
            shadow[(s*5+t)*COEFF_W +: COEFF_W] <= wr_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_xover_coeff_scheduler.sv
// Scoreboard bench for xover_coeff_scheduler: directed writes/commits, expected events queued
// at stimulus time and matched by an independent monitor on the falling edge.
module tb_xover_coeff_scheduler;

  localparam int NX = 3;
  localparam int CW = 16;
  localparam int TW = NX * 5 * CW;
  // Long enough to cover the 50-cycle hold before the sample strobe.
  localparam int TO = 64;
`ifdef XOVER_STABILITY_CHECK_EN
  localparam int CHK = NX;
`else
  localparam int CHK = 1;
`endif

  logic          clk, rst;
  logic          wr_valid, wr_ready;
  logic [1:0]    wr_stage;
  logic [2:0]    wr_tap;
  logic [CW-1:0] wr_data;
  logic          commit_req, sample_valid;
  logic          busy, commit_ack, commit_err, err_addr, coeff_update;
  logic [TW-1:0] coeffs_out;

  xover_coeff_scheduler #(.NUM_XOVER(NX), .COEFF_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_stage(wr_stage),
    .wr_tap(wr_tap), .wr_data(wr_data), .commit_req(commit_req), .sample_valid(sample_valid),
    .busy(busy), .commit_ack(commit_ack), .commit_err(commit_err), .err_addr(err_addr),
    .coeff_update(coeff_update), .coeffs_out(coeffs_out)
  );

  typedef struct {
    bit            ack;
    bit            err;
    bit            upd;
    logic [TW-1:0] coeffs;
    int            at;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic [CW-1:0] shadow_m [NX][5];
  logic [TW-1:0] act_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [TW-1:0] pack_m();
    logic [TW-1:0] v;
    for (int s = 0; s < NX; s++)
      for (int t = 0; t < 5; t++)
        v[(s*5+t)*CW +: CW] = shadow_m[s][t];
    return v;
  endfunction

  task automatic reset_model();
    for (int s = 0; s < NX; s++)
      for (int t = 0; t < 5; t++)
        shadow_m[s][t] = (t == 0) ? 16'd16384 : 16'd0;
    act_m = pack_m();
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, a, x);
    end
  endtask

  task automatic chk_coeffs(input string nm, input logic [TW-1:0] x);
    total++;
    if (coeffs_out !== x) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, coeffs_out, x);
    end
  endtask

  task automatic wr(input int s, input int t, input logic [CW-1:0] d);
    @(negedge clk);
    chk("wr_ready", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_stage = 2'(s);
    wr_tap   = 3'(t);
    wr_data  = d;
    if (s < NX && t < 5) shadow_m[s][t] = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic commit(output int c);
    @(negedge clk);
    commit_req = 1'b1;
    c = cyc;
    @(negedge clk);
    commit_req = 1'b0;
  endtask

  task automatic push(input bit a, input bit e, input bit u, input logic [TW-1:0] cf, input int at);
    exp_t x;
    x.ack = a; x.err = e; x.upd = u; x.coeffs = cf; x.at = at;
    sb.push_back(x);
  endtask

  // Sample strobe while in PEND: new coefficients visible two edges later.
  task automatic pulse_sample();
    @(negedge clk);
    sample_valid = 1'b1;
    act_m = pack_m();
    push(1'b1, 1'b0, 1'b1, act_m, cyc + 2);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic noop_commit();
    @(negedge clk);
    commit_req = 1'b1;
    push(1'b1, 1'b0, 1'b0, act_m, cyc + 1);
    @(negedge clk);
    commit_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d", sb.size());
      sb.delete();
    end
  endtask

  initial begin : monitor
    exp_t          e;
    logic [TW-1:0] prev;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = coeffs_out;
      end else begin
        if (commit_ack || commit_err || coeff_update) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event cyc=%0d ack=%b err=%b upd=%b", cyc, commit_ack, commit_err, coeff_update);
          end else begin
            e = sb.pop_front();
            if (commit_ack !== e.ack || commit_err !== e.err || coeff_update !== e.upd ||
                coeffs_out !== e.coeffs || cyc != e.at) begin
              bad++;
              $display("FAIL event cyc=%0d exp_cyc=%0d ack=%b/%b err=%b/%b upd=%b/%b coeffs=%h exp=%h",
                       cyc, e.at, commit_ack, e.ack, commit_err, e.err, coeff_update, e.upd, coeffs_out, e.coeffs);
            end
          end
        end else begin
          total++;
          if (coeffs_out !== prev) begin
            bad++;
            $display("FAIL coeffs_stable cyc=%0d got=%h exp=%h", cyc, coeffs_out, prev);
          end
        end
        prev = coeffs_out;
      end
    end
  end

  initial begin : stim
    int c;
    rst = 1'b1; wr_valid = 1'b0; wr_stage = 2'd0; wr_tap = 3'd0; wr_data = '0;
    commit_req = 1'b0; sample_valid = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk_coeffs("reset_coeffs", act_m);
    chk("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_err_addr", {31'd0, err_addr}, 32'd0);
    chk("reset_ack", {31'd0, commit_ack}, 32'd0);

    // Stage1 a1=-20000, held in PEND for 50 cycles, then a sample strobe
`ifdef XOVER_STABILITY_CHECK_EN
    wr(1, 4, 16'd8000);
`endif
    wr(1, 3, 16'hB1E0);
    commit(c);
    repeat (50) @(negedge clk);
    chk("pend_busy", {31'd0, busy}, 32'd1);
    chk("pend_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk_coeffs("pend_unchanged", act_m);
    pulse_sample();
    drain();
    chk("post_swap_busy", {31'd0, busy}, 32'd0);

    // Timeout-forced swap; write and commit while busy are ignored
    wr(0, 0, 16'd12000);
    commit(c);
    act_m = pack_m();
    push(1'b1, 1'b0, 1'b1, act_m, c + 2 + CHK + TO);
    repeat (5) @(negedge clk);
    wr_valid = 1'b1; wr_stage = 2'd2; wr_tap = 3'd0; wr_data = 16'h7777; commit_req = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; commit_req = 1'b0;
    drain();
    chk("err_addr_clear", {31'd0, err_addr}, 32'd0);

    // Invalid addresses are dropped, then a no-op commit
    wr(0, 6, 16'h1234);
    chk("err_addr_tap", {31'd0, err_addr}, 32'd1);
    wr(3, 0, 16'h5555);
    chk("err_addr_stage", {31'd0, err_addr}, 32'd1);
    noop_commit();
    drain();
    chk("noop_busy", {31'd0, busy}, 32'd0);
    chk("err_addr_sticky", {31'd0, err_addr}, 32'd1);

    // Write and commit in the same cycle
    @(negedge clk);
    wr_valid = 1'b1; wr_stage = 2'd2; wr_tap = 3'd2; wr_data = 16'h0400; commit_req = 1'b1;
    shadow_m[2][2] = 16'h0400;
    @(negedge clk);
    wr_valid = 1'b0; commit_req = 1'b0;
    repeat (4) @(negedge clk);
    pulse_sample();
    drain();

`ifdef XOVER_STABILITY_CHECK_EN
    // Unstable stage0 a2 rejected, corrected value accepted
    wr(0, 4, 16'h4000);
    commit(c);
    push(1'b0, 1'b1, 1'b0, act_m, c + 2);
    drain();
    chk("stab_busy", {31'd0, busy}, 32'd0);
    chk("stab_wr_ready", {31'd0, wr_ready}, 32'd1);
    wr(0, 4, 16'd8000);
    commit(c);
    repeat (5) @(negedge clk);
    pulse_sample();
    drain();
`endif

    // Reset in the middle of a pending commit
    wr(1, 0, 16'd100);
    commit(c);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_model();
    chk_coeffs("midreset_coeffs", act_m);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_err_addr", {31'd0, err_addr}, 32'd0);
    chk("midreset_wr_ready", {31'd0, wr_ready}, 32'd1);
    noop_commit();
    drain();

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
